// File: rtl/pattern_gen_mc.sv
// pattern_gen_mc: multi-mode VGA test-pattern generator, fixed 2-cycle latency on colour, de and syncs.
// Optional frame border overlay is built when PATTERN_BORDER_EN is defined.
module pattern_gen_mc #(
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned SPEED_W    = 4,
  parameter int unsigned GRAD_SHIFT = 5,
  parameter int unsigned BAR_SHIFT  = 6,
  parameter int unsigned CHK_SHIFT  = 4,
  parameter int unsigned FCNT_W     = 16,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               de_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [2:0]         mode_sel,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  input  logic               freeze,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               de_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam int unsigned MODE_W = 3;
  localparam logic [COLOR_W-1:0] MAX = '1;

  logic                 vsync_d_q, vsync_d_d;
  logic [MODE_W-1:0]    mode_act_q, mode_act_d;
  logic [COORD_W-1:0]   offset_q, offset_d;
  logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                 frame_edge_c;

  logic [COORD_W-1:0]   s1_x_q, s1_x_d;
  logic [COORD_W-1:0]   s1_y_q, s1_y_d;
  logic                 s1_de_q, s1_de_d;
  logic                 s1_hs_q, s1_hs_d;
  logic                 s1_vs_q, s1_vs_d;
  logic [MODE_W-1:0]    s1_mode_q, s1_mode_d;
`ifdef PATTERN_BORDER_EN
  logic                 s1_border_q, s1_border_d;
`endif

  logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic                 de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [2:0]           bar_idx_c;
  logic                 unused_c;

  // Frame-boundary control: mode, scroll offset and frame count only move on a vsync rising edge
  always_comb begin
    vsync_d_d    = vsync_in;
    mode_act_d   = mode_act_q;
    offset_d     = offset_q;
    frame_cnt_d  = frame_cnt_q;
    frame_edge_c = vsync_in & ~vsync_d_q;
    if (frame_edge_c) begin
      mode_act_d  = mode_sel;
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      if (!freeze) begin
        offset_d = dir ? (offset_q - COORD_W'(speed)) : (offset_q + COORD_W'(speed));
      end
    end
  end

  // Stage 1: scrolled column plus the mode in force when this pixel arrived
  always_comb begin
    s1_x_d    = x + offset_q;
    s1_y_d    = y;
    s1_de_d   = de_in;
    s1_hs_d   = hsync_in;
    s1_vs_d   = vsync_in;
    s1_mode_d = mode_act_q;
`ifdef PATTERN_BORDER_EN
    s1_border_d = de_in && ((x == '0) || (x == COORD_W'(H_ACTIVE - 1)) ||
                            (y == '0) || (y == COORD_W'(V_ACTIVE - 1)));
`endif
  end

  // Stage 2: colour generation, border override, de blanking
  always_comb begin
    r_d       = '0;
    g_d       = '0;
    b_d       = '0;
    de_d      = s1_de_q;
    hs_d      = s1_hs_q;
    vs_d      = s1_vs_q;
    bar_idx_c = s1_x_q[BAR_SHIFT +: 3];
    case (s1_mode_q)
      3'd0: begin
        r_d = s1_x_q[GRAD_SHIFT +: COLOR_W];
        g_d = s1_y_q[GRAD_SHIFT +: COLOR_W];
        b_d = MAX - s1_x_q[GRAD_SHIFT +: COLOR_W];
      end
      3'd1: begin
        // bar order white..black reduces to inverted index bits per channel
        r_d = {COLOR_W{~bar_idx_c[1]}};
        g_d = {COLOR_W{~bar_idx_c[2]}};
        b_d = {COLOR_W{~bar_idx_c[0]}};
      end
      3'd2: begin
        r_d = {COLOR_W{s1_x_q[CHK_SHIFT] ^ s1_y_q[CHK_SHIFT]}};
        g_d = r_d;
        b_d = r_d;
      end
      3'd3: begin
        r_d = s1_y_q[GRAD_SHIFT +: COLOR_W];
        g_d = r_d;
        b_d = r_d;
      end
      default: begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end
    endcase
`ifdef PATTERN_BORDER_EN
    if (s1_border_q) begin
      r_d = MAX;
      g_d = MAX;
      b_d = MAX;
    end
`endif
    if (!s1_de_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // Coordinate bits outside the pattern slices are intentionally dropped
  assign unused_c = ^{s1_x_q, s1_y_q, H_ACTIVE, V_ACTIVE};

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_q   <= 1'b1;
      mode_act_q  <= '0;
      offset_q    <= '0;
      frame_cnt_q <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_de_q     <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_mode_q   <= '0;
`ifdef PATTERN_BORDER_EN
      s1_border_q <= 1'b0;
`endif
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      vsync_d_q   <= vsync_d_d;
      mode_act_q  <= mode_act_d;
      offset_q    <= offset_d;
      frame_cnt_q <= frame_cnt_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_de_q     <= s1_de_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_mode_q   <= s1_mode_d;
`ifdef PATTERN_BORDER_EN
      s1_border_q <= s1_border_d;
`endif
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign de_out    = de_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pattern_gen_mc.sv
// Self-checking bench for pattern_gen_mc: reference model feeds a scoreboard queue, popped 2 cycles later.
module tb_pattern_gen_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x, y;
  logic        de_in, hsync_in, vsync_in;
  logic [2:0]  mode_sel;
  logic [3:0]  speed;
  logic        dir, freeze;
  logic [3:0]  r, g, b;
  logic        de_out, hsync_out, vsync_out;
  logic [15:0] frame_cnt;

  pattern_gen_mc dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .de_in(de_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .mode_sel(mode_sel), .speed(speed), .dir(dir), .freeze(freeze),
    .r(r), .g(g), .b(b), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};

  logic [14:0] obs_w;
  assign obs_w = {r, g, b, de_out, hsync_out, vsync_out};

  logic [14:0] sb_q [$];
  logic [14:0] exp_w;
  logic        have_exp;
  logic [10:0] m_off;
  logic [2:0]  m_mode;
  logic [15:0] m_fcnt;
  logic        m_vs_d;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [14:0] model_px(input logic [10:0] px, input logic [10:0] py,
                                           input logic pde, input logic phs, input logic pvs);
    logic [10:0] xm;
    logic [3:0]  cr, cg, cb;
    logic [2:0]  bar;
    xm = px + m_off;
    cr = 4'd0; cg = 4'd0; cb = 4'd0;
    case (m_mode)
      3'd0: begin cr = xm[8:5]; cg = py[8:5]; cb = 4'd15 - cr; end
      3'd1: begin
        bar = BAR_RGB[xm[8:6]];
        cr = {4{bar[2]}}; cg = {4{bar[1]}}; cb = {4{bar[0]}};
      end
      3'd2: if (xm[4] ^ py[4]) begin cr = 4'd15; cg = 4'd15; cb = 4'd15; end
      3'd3: begin cr = py[8:5]; cg = py[8:5]; cb = py[8:5]; end
      default: ;
    endcase
`ifdef PATTERN_BORDER_EN
    if (pde && (px == 11'd0 || px == 11'd639 || py == 11'd0 || py == 11'd479)) begin
      cr = 4'd15; cg = 4'd15; cb = 4'd15;
    end
`endif
    if (!pde) begin cr = 4'd0; cg = 4'd0; cb = 4'd0; end
    return {cr, cg, cb, pde, phs, pvs};
  endfunction

  // One clock: push the expected pixel, advance the model, pop what is due at the outputs
  task automatic tick();
    if (rst) begin
      sb_q.delete();
      sb_q.push_back(15'd0);
      m_off = 11'd0; m_mode = 3'd0; m_fcnt = 16'd0; m_vs_d = 1'b1;
    end else begin
      sb_q.push_back(model_px(x, y, de_in, hsync_in, vsync_in));
      if (vsync_in && !m_vs_d) begin
        m_mode = mode_sel;
        m_fcnt = m_fcnt + 16'd1;
        if (!freeze) m_off = dir ? (m_off - 11'(speed)) : (m_off + 11'(speed));
      end
      m_vs_d = vsync_in;
    end
    @(posedge clk);
    #1;
    have_exp = 1'b0;
    if (sb_q.size() >= 2) begin
      exp_w = sb_q.pop_front();
      have_exp = 1'b1;
    end
  endtask

  task automatic px(input int unsigned xv, input int unsigned yv, input logic dv);
    x = 11'(xv); y = 11'(yv); de_in = dv;
  endtask

  task automatic test_reset();
    rst = 1'b1; px(0, 0, 1'b0); hsync_in = 1'b0; vsync_in = 1'b0;
    mode_sel = 3'd0; speed = 4'd0; dir = 1'b0; freeze = 1'b0;
    tick(); tick();
    n_checks++;
    if (obs_w !== 15'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs_w); end
    n_checks++;
    if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
  endtask

  task automatic test_gradient();
    rst = 1'b0; px(32, 64, 1'b1);
    repeat (3) begin
      tick();
      if (have_exp) begin
        n_checks++;
        if (obs_w !== exp_w) begin n_fail++; $display("FAIL gradient_sb: got %h expected %h", obs_w, exp_w); end
      end
    end
    n_checks++;
    if ({r, g, b, de_out} !== {4'd1, 4'd2, 4'd14, 1'b1}) begin
      n_fail++; $display("FAIL gradient_const: got r=%0d g=%0d b=%0d de=%0d expected 1 2 14 1", r, g, b, de_out);
    end
  endtask

  task automatic test_scroll();
    speed = 4'd3; dir = 1'b0; px(0, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      vsync_in = (i % 4) < 2;
      tick();
      if (have_exp) begin
        n_checks++;
        if (obs_w !== exp_w) begin n_fail++; $display("FAIL scroll_sb: got %h expected %h", obs_w, exp_w); end
      end
    end
    n_checks++;
    if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL scroll_fcnt: got %0d expected 4", frame_cnt); end
    px(20, 1, 1'b1);
    repeat (3) begin
      tick();
      n_checks++;
      if (obs_w !== exp_w) begin n_fail++; $display("FAIL scroll_fwd_sb: got %h expected %h", obs_w, exp_w); end
    end
    n_checks++;
    if ({r, g, b} !== {4'd1, 4'd0, 4'd14}) begin
      n_fail++; $display("FAIL scroll_fwd_const: got r=%0d g=%0d b=%0d expected 1 0 14", r, g, b);
    end
    dir = 1'b1; speed = 4'd15; px(0, 0, 1'b0);
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0; tick();
    px(35, 1, 1'b1);
    repeat (3) begin
      tick();
      n_checks++;
      if (obs_w !== exp_w) begin n_fail++; $display("FAIL scroll_rev_sb: got %h expected %h", obs_w, exp_w); end
    end
    n_checks++;
    if ({r, b} !== {4'd1, 4'd14}) begin
      n_fail++; $display("FAIL scroll_wrap_const: got r=%0d b=%0d expected 1 14", r, b);
    end
    n_checks++;
    if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL scroll_fcnt2: got %0d expected 5", frame_cnt); end
  endtask

  task automatic test_mode_change();
    rst = 1'b1; vsync_in = 1'b0; tick();
    rst = 1'b0; speed = 4'd0; dir = 1'b0; freeze = 1'b0; mode_sel = 3'd1;
    px(64, 1, 1'b1);
    repeat (3) begin
      tick();
      if (have_exp) begin
        n_checks++;
        if (obs_w !== exp_w) begin n_fail++; $display("FAIL mode_hold_sb: got %h expected %h", obs_w, exp_w); end
      end
    end
    n_checks++;
    if ({r, g, b} !== {4'd2, 4'd0, 4'd13}) begin
      n_fail++; $display("FAIL mode_hold_const: got r=%0d g=%0d b=%0d expected 2 0 13", r, g, b);
    end
    for (int i = 0; i < 4; i++) begin
      vsync_in = (i == 0);
      tick();
      n_checks++;
      if (obs_w !== exp_w) begin n_fail++; $display("FAIL mode_switch_sb: got %h expected %h", obs_w, exp_w); end
    end
    n_checks++;
    if ({r, g, b} !== {4'd15, 4'd15, 4'd0}) begin
      n_fail++; $display("FAIL mode_bars_const: got r=%0d g=%0d b=%0d expected 15 15 0", r, g, b);
    end
  endtask

  task automatic test_freeze();
    mode_sel = 3'd0; speed = 4'd5; freeze = 1'b1; px(0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      vsync_in = (i % 2) == 0;
      tick();
      n_checks++;
      if (obs_w !== exp_w) begin n_fail++; $display("FAIL freeze_sb: got %h expected %h", obs_w, exp_w); end
    end
    n_checks++;
    if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL freeze_fcnt: got %0d expected 4", frame_cnt); end
    px(31, 1, 1'b1);
    repeat (3) tick();
    n_checks++;
    if ({r, b} !== {4'd0, 4'd15}) begin
      n_fail++; $display("FAIL freeze_offset: got r=%0d b=%0d expected 0 15", r, b);
    end
    freeze = 1'b0; speed = 4'd0;
    rst = 1'b1; vsync_in = 1'b1; tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      n_checks++;
      if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_vsync_high: got %0d expected 0", frame_cnt); end
    end
    vsync_in = 1'b0; tick();
    vsync_in = 1'b1; tick();
    n_checks++;
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_first_edge: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_checker();
    px(0, 0, 1'b0); mode_sel = 3'd2;
    vsync_in = 1'b0; tick();
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0;
    px(16, 0, 1'b1);
    repeat (3) tick();
    n_checks++;
    if ({r, g, b} !== 12'hFFF) begin n_fail++; $display("FAIL checker_on: got %h expected fff", {r, g, b}); end
    px(16, 16, 1'b1);
    repeat (3) tick();
    n_checks++;
    if ({r, g, b} !== 12'h000) begin n_fail++; $display("FAIL checker_off: got %h expected 000", {r, g, b}); end
    mode_sel = 3'd5; px(0, 0, 1'b0);
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0;
    px(16, 1, 1'b1);
    repeat (3) tick();
    n_checks++;
    if ({r, g, b} !== 12'h000) begin n_fail++; $display("FAIL reserved_mode: got %h expected 000", {r, g, b}); end
    mode_sel = 3'd2; px(16, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      hsync_in = i[0]; vsync_in = i[1];
      tick();
      n_checks++;
      if (obs_w !== exp_w) begin n_fail++; $display("FAIL de_low_sync_sb: got %h expected %h", obs_w, exp_w); end
    end
    hsync_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic test_border();
    logic [11:0] want;
    mode_sel = 3'd4; px(0, 0, 1'b0);
    vsync_in = 1'b0; tick();
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0;
    px(639, 100, 1'b1);
    repeat (3) tick();
`ifdef PATTERN_BORDER_EN
    want = 12'hFFF;
`else
    want = 12'h000;
`endif
    n_checks++;
    if ({r, g, b} !== want) begin n_fail++; $display("FAIL border_pixel: got %h expected %h", {r, g, b}, want); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      x = 11'($urandom_range(0, 2047));
      y = 11'($urandom_range(0, 2047));
      de_in = ($urandom_range(0, 3) != 0);
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = ((i % 23) < 3) || ($urandom_range(0, 15) == 0);
      mode_sel = 3'($urandom_range(0, 7));
      speed = 4'($urandom_range(0, 15));
      dir = 1'($urandom_range(0, 1));
      freeze = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if (obs_w !== exp_w) begin n_fail++; $display("FAIL random_sb[%0d]: got %h expected %h", i, obs_w, exp_w); end
      n_checks++;
      if (frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL random_fcnt[%0d]: got %0d expected %0d", i, frame_cnt, m_fcnt); end
    end
  endtask

  initial begin
    test_reset();
    test_gradient();
    test_scroll();
    test_mode_change();
    test_freeze();
    test_checker();
    test_border();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_gen_mc.md
Name: pattern_gen_mc

Overview:
Parametrised multi-mode VGA test-pattern generator. Sits between the VGA timing generator and the pad-level RGB/sync outputs. Consumes pixel coordinates, data-enable and syncs, and produces colour plus delay-matched syncs. Supports four patterns, programmable scroll speed and direction, and mode changes that are glitch-free at frame boundaries.

Parameters:
COORD_W, 11, width of x/y coordinates and scroll offset
COLOR_W, 4, bits per colour channel
SPEED_W, 4, width of scroll speed input
GRAD_SHIFT, 5, LSB of coordinate slice used for gradient and ramp modes
BAR_SHIFT, 6, log2 of colour-bar width in pixels
CHK_SHIFT, 4, log2 of checkerboard cell size in pixels
FCNT_W, 16, frame counter width
H_ACTIVE, 640, active width (border feature only)
V_ACTIVE, 480, active height (border feature only)

Ports:
clk  in  1  pixel clock
rst  in  1  reset; synchronous, active-high
x  in  COORD_W  current pixel column
y  in  COORD_W  current pixel row
de_in  in  1  data enable (active pixel region)
hsync_in  in  1  horizontal sync, passed through
vsync_in  in  1  vertical sync, active-high, passed through
mode_sel  in  3  requested pattern mode
speed  in  SPEED_W  requested scroll step per frame
dir  in  1  0 = offset increments, 1 = offset decrements
freeze  in  1  1 = hold scroll offset
r  out  COLOR_W  red
g  out  COLOR_W  green
b  out  COLOR_W  blue
de_out  out  1  delayed de_in
hsync_out  out  1  delayed hsync_in
vsync_out  out  1  delayed vsync_in
frame_cnt  out  FCNT_W  frames since reset

Behaviour:
- Reset (rst high at a clk edge): r/g/b/de_out/hsync_out/vsync_out = 0; frame_cnt = 0; offset = 0; mode_act = 0; vsync_d = 1, so a vsync_in held high coming out of reset is not treated as an edge.
- Frame edge = vsync_in & ~vsync_d, where vsync_d is vsync_in registered. On a frame edge:
  - mode_act <= mode_sel.
  - frame_cnt <= frame_cnt + 1, wrapping mod 2^FCNT_W. This happens even when freeze = 1.
  - If freeze = 0: offset <= offset + speed (dir = 0) or offset - speed (dir = 1). The current speed input is zero-extended to COORD_W, and the result wraps mod 2^COORD_W.
- mode_sel, speed, dir and freeze are ignored except on the frame-edge cycle.
- x_mov = (x + offset) mod 2^COORD_W.
- Pipeline, fixed latency 2 cycles for every output:
  - Stage 1 registers x_mov, y, de, hsync, vsync.
  - Stage 2 registers the colour and the delayed sync/de.
  - A frame edge at cycle N affects pixels entering at cycle N+1 onward.
- Define slice(v, s) = v[s+COLOR_W-1 : s] and MAX = 2^COLOR_W - 1.
- Modes (mode_act):
  - 0, scrolling gradient: r = slice(x_mov, GRAD_SHIFT); g = slice(y, GRAD_SHIFT); b = MAX - r.
  - 1, colour bars: idx = x_mov[BAR_SHIFT+2 : BAR_SHIFT]. Order by idx 0..7: white, yellow, cyan, green, magenta, red, blue, black. Each channel is MAX or 0 (rgb = 111, 110, 011, 010, 101, 100, 001, 000).
  - 2, checkerboard: r = g = b = MAX if x_mov[CHK_SHIFT] ^ y[CHK_SHIFT], else 0.
  - 3, grey ramp: r = g = b = slice(y, GRAD_SHIFT).
  - 4..7, reserved: r = g = b = 0.
- Whenever the delayed de is 0, r = g = b = 0, regardless of mode.
- Syncs are never modified, only delayed.
- rst asserted mid-frame clears the pipeline on that edge: outputs read 0 for 2 cycles after rst is released, then valid data follows.

Optional Feature:
Macro PATTERN_BORDER_EN.
- Defined: when de is high and (x == 0, x == H_ACTIVE-1, y == 0 or y == V_ACTIVE-1), output r = g = b = MAX, overriding every mode including reserved ones. Unscrolled x is used and it is pipelined identically (latency stays 2).
- Undefined: no border logic; H_ACTIVE and V_ACTIVE are unused.

Test Plan:
- Reset, then drive de_in = 1, x = 32, y = 64, mode 0, offset 0 -> after 2 cycles r = 1, g = 2, b = 14; de_out = 1.
- speed = 3, dir = 0, four vsync rising edges -> offset = 12, frame_cnt = 4. Then dir = 1, speed = 15, one edge -> offset = 2045 (wrap mod 2048).
- Change mode_sel 0 -> 1 mid-frame -> output stays gradient until the next vsync edge, then bars. x = 64 (idx 1) -> r = 15, g = 15, b = 0.
- freeze = 1 across 3 edges -> offset unchanged, frame_cnt increases by 3. Also: rst released with vsync_in high -> frame_cnt stays 0 until the next rising edge.
- mode 2 at x = 16, y = 0 -> all channels 15; x = 16, y = 16 -> 0. mode 5 -> all channels 0. Any mode with de_in = 0 -> rgb 0 while hsync/vsync still toggle with 2-cycle delay.
- With PATTERN_BORDER_EN defined, mode 4, x = 639, y = 100, de = 1 -> rgb = 15/15/15. Same pixel without the macro -> 0/0/0.
